fft_sram_responder: RTL

//  Memory-side responder for the fft_top SRAM interface: a DEPTH x WIDTH buffer that serves the

---
 rtl/fft_sram_responder.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/fft_sram_responder.sv
// DEPTH x WIDTH buffer shared between the FFT core (2 read / 2 write ports) and a host load/unload port.
// Optional feature: define FFT_SRAM_WR_FWD_EN to forward same-cycle core write data into the core read registers.
module fft_sram_responder #(
  parameter int DEPTH = 256,
  parameter int WIDTH = 128,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_working,
  input  logic [AW-1:0]    i_raddress1,
  input  logic [AW-1:0]    i_raddress2,
  input  logic             i_sram_read_register,
  output logic [WIDTH-1:0] o_rdata1,
  output logic [WIDTH-1:0] o_rdata2,
  input  logic [AW-1:0]    i_waddress1,
  input  logic [AW-1:0]    i_waddress2,
  input  logic [WIDTH-1:0] i_wdata1,
  input  logic [WIDTH-1:0] i_wdata2,
  input  logic             i_global_write_enable,
  input  logic             i_host_valid,
  input  logic             i_host_we,
  input  logic [AW-1:0]    i_host_addr,
  input  logic [WIDTH-1:0] i_host_wdata,
  output logic             o_host_ready,
  output logic             o_host_rvalid,
  output logic [WIDTH-1:0] o_host_rdata,
  output logic             o_wr_collision,
  output logic [1:0]       o_dbg_state
);

  // Host handshake: a request transfers on a rising edge where i_host_valid && o_host_ready.
  // Writes commit at that edge; reads return o_host_rdata with a one-cycle o_host_rvalid pulse.
  typedef enum logic [1:0] {
    S_HOST  = 2'd0,
    S_FFT   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             host_ready_q, host_ready_d;
  logic             host_rvalid_q, host_rvalid_d;
  logic [WIDTH-1:0] host_rdata_q, host_rdata_d;
  logic [WIDTH-1:0] rdata1_q, rdata1_d;
  logic [WIDTH-1:0] rdata2_q, rdata2_d;
  logic             collision_q, collision_d;

  logic             core_own;
  logic             core_we;
  logic             host_we;
  logic             host_re;

  logic [WIDTH-1:0] mem [DEPTH];

  function automatic logic in_range(input logic [AW-1:0] a);
    return (32'(a) < DEPTH);
  endfunction

  function automatic logic [WIDTH-1:0] mem_rd(input logic [AW-1:0] a);
    return in_range(a) ? mem[a] : '0;
  endfunction

  // Core-port read value; with forwarding, port 2 wins like it does in the array.
  function automatic logic [WIDTH-1:0] core_rd(input logic [AW-1:0] a);
    logic [WIDTH-1:0] v;
    v = mem_rd(a);
`ifdef FFT_SRAM_WR_FWD_EN
    if (core_we && in_range(a)) begin
      if (a == i_waddress2)      v = i_wdata2;
      else if (a == i_waddress1) v = i_wdata1;
    end
`endif
    return v;
  endfunction

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_HOST:  if (i_working)  state_d = S_FFT;
      S_FFT:   if (!i_working) state_d = S_DRAIN;
      S_DRAIN: state_d = S_HOST;
      default: state_d = S_HOST;
    endcase

    core_own = (state_q == S_FFT) || (state_q == S_DRAIN);
    core_we  = core_own && i_global_write_enable;
    host_we  = i_host_valid && host_ready_q && i_host_we;
    host_re  = i_host_valid && host_ready_q && !i_host_we;

    // Registered ready: a request presented in the cycle i_working rises still completes.
    host_ready_d  = (state_d == S_HOST) && !i_working;
    host_rvalid_d = host_re;
    host_rdata_d  = host_re ? mem_rd(i_host_addr) : host_rdata_q;
    collision_d   = core_we && (i_waddress1 == i_waddress2);

    rdata1_d = rdata1_q;
    rdata2_d = rdata2_q;
    if (core_own && i_sram_read_register) begin
      rdata1_d = core_rd(i_raddress1);
      rdata2_d = core_rd(i_raddress2);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_HOST;
      host_ready_q  <= 1'b0;
      host_rvalid_q <= 1'b0;
      host_rdata_q  <= '0;
      rdata1_q      <= '0;
      rdata2_q      <= '0;
      collision_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      host_ready_q  <= host_ready_d;
      host_rvalid_q <= host_rvalid_d;
      host_rdata_q  <= host_rdata_d;
      rdata1_q      <= rdata1_d;
      rdata2_q      <= rdata2_d;
      collision_q   <= collision_d;
    end
  end

  // Array has no reset so contents survive rst; port 2 is written last and wins on collision.
  always_ff @(posedge clk) begin
    if (core_we) begin
      if (in_range(i_waddress1)) mem[i_waddress1] <= i_wdata1;
      if (in_range(i_waddress2)) mem[i_waddress2] <= i_wdata2;
    end
    if (host_we && in_range(i_host_addr)) mem[i_host_addr] <= i_host_wdata;
  end

  assign o_rdata1       = rdata1_q;
  assign o_rdata2       = rdata2_q;
  assign o_host_ready   = host_ready_q;
  assign o_host_rvalid  = host_rvalid_q;
  assign o_host_rdata   = host_rdata_q;
  assign o_wr_collision = collision_q;
  assign o_dbg_state    = state_q;

endmodule
